quiz_round_ctrl: RTL and testbench
==================================

Name: quiz_round_ctrl

Overview:
Round sequencer and buzz-in arbiter for the 4-player responder.
- Consumes debounced player keys and host buttons; runs the ARM → OPEN → ANSWER → judge cycle.
- Grants exactly one player per buzz using round-robin priority, keeps a BCD countdown, and maintains a 0-9 score per player.
- Drives the display (player number, timer digits) and the buzzer event pulses; replaces the free-running first-press selector.

Parameters:
- TICK_DIV, 50000000, clock cycles per countdown second (≥2).
- ARM_SECS, 3, ARMED-phase countdown in seconds (BCD 1-99).
- OPEN_SECS, 10, buzz-in window in seconds (BCD 1-99).
- ANS_SECS, 20, answer window in seconds (BCD 1-99).

Ports:
- CLK input 1 system clock.
- RSTn input 1 asynchronous active-low reset.
- Key_In input 4 debounced player keys, active-high level; bit i = player i+1.
- Host_Start input 1 debounced host start/abort level.
- Host_Correct input 1 debounced host "correct" level.
- Host_Wrong input 1 debounced host "wrong" level.
- Score_Clear input 1 one-cycle pulse; clears all scores, honoured in IDLE only.
- Player_Number output 4 winner 1-4; 0 = none.
- TimerH output 4 countdown tens, BCD.
- TimerL output 4 countdown units, BCD.
- Lockout output 4 per-player lockout flags.
- Score output 16 four 4-bit BCD scores; [3:0] = player 1.
- Buzzer_Answer output 1 one-cycle pulse on grant.
- Buzzer_TimeOver output 1 one-cycle pulse on any timeout.
- State_Out output 3 current state encoding.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer → player 1 highest priority; prescaler 0.
- All level inputs are rising-edge detected internally, giving 1-cycle internal pulses.
- States (encoding): IDLE=0, ARMED=1, OPEN=2, ANSWER=3, JUDGE=4.
- IDLE:
  - Timer shows 00; Player_Number 0.
  - Host_Start edge → ARMED: timer loaded ARM_SECS, Lockout cleared.
- ARMED:
  - Countdown runs.
  - At 00 → OPEN: timer loaded OPEN_SECS.
- OPEN:
  - Any key edge from a non-locked player is a request.
  - Grant goes to the requester first at or after the RR pointer.
  - On grant, same cycle as the transition:
    - Player_Number = winner.
    - Buzzer_Answer = 1 for 1 cycle.
    - Pointer moves to winner+1 (mod 4).
    - → ANSWER: timer loaded ANS_SECS.
  - Timer reaches 00 without a grant → Buzzer_TimeOver pulse, → IDLE.
- ANSWER:
  - Further key edges are ignored.
  - Host_Correct edge → JUDGE with verdict correct.
  - Host_Wrong edge, or timer reaching 00, → JUDGE with verdict wrong; a timeout also pulses Buzzer_TimeOver.
  - Host_Correct and Host_Wrong in the same cycle: correct wins.
- JUDGE (1 cycle):
  - Correct: winner score +1, saturating at 9; → IDLE; Player_Number held until the next Host_Start.
  - Wrong: set the winner's Lockout bit and clear Player_Number.
    - If all 4 Lockout bits are now set → IDLE.
    - Otherwise → OPEN, timer reloaded OPEN_SECS.
- Countdown and prescaler:
  - Every state load resets the prescaler, so the first second is a full TICK_DIV cycles.
  - On each tick, BCD decrement: units 0 → 9 with tens −1.
  - The timer never goes below 00.
- Host_Start edge in ARMED, OPEN or ANSWER aborts the round:
  - → IDLE; scores unchanged; Lockout cleared; no buzzer pulse.
- A Host_Start edge coincident with a grant or timeout takes precedence (abort).
- Score_Clear outside IDLE is ignored.
- Reset asserted mid-round: immediate return to all reset values, scores included.

Optional Feature:
- Macro: FALSE_START_LOCKOUT_EN.
- Defined: a key edge during ARMED sets that player's Lockout bit for the round. If all 4 players become locked during ARMED, the round ends → IDLE at ARMED expiry with a Buzzer_TimeOver pulse.
- Undefined: key edges during ARMED are ignored; Lockout changes only in JUDGE.

Decomposition:
- Package responder_pkg:
  - State enum and its 3-bit encodings.
  - NUM_PLAYERS = 4.
  - BCD digit typedef (4 bit) and a BCD-pair struct.
  - Score saturation constant 9.
- Sub-module rr_arbiter4:
  - Inputs: req[3:0], mask[3:0], ptr[1:0].
  - Outputs: grant[3:0] one-hot, valid.
  - Purely combinational; the pointer register lives in the parent.

Test Plan (TICK_DIV=4, ARM_SECS=2, OPEN_SECS=3, ANS_SECS=2):
1. Host_Start; after 2 s press player 3 → ARMED lasts 8 cycles; Player_Number=3; Buzzer_Answer 1 pulse; timer=02.
2. From reset, players 2 and 4 press in the same cycle during OPEN → grant 2; pointer→3. Next round, 2 and 4 together again → grant 4.
3. Grant player 1, Host_Wrong → Lockout=0001; OPEN reloaded 03. Player 1 presses again → ignored. Player 2 presses → granted.
4. Grant player 4, Host_Correct ×10 rounds → Score[15:12] reaches 9 and stays 9.
5. OPEN with no presses → after 12 cycles Buzzer_TimeOver pulse; IDLE; timer 00.
6. FALSE_START_LOCKOUT_EN defined: player 2 presses in ARMED → Lockout=0010 and player 2 is not granted in OPEN. Also: RSTn low mid-ANSWER → all outputs 0 asynchronously.

Source files
------------

// File: rtl/responder_pkg.sv
// Shared types and constants for the quiz responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package responder_pkg;

    localparam int NUM_PLAYERS = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_OPEN   = 3'd2;
    localparam logic [2:0] ST_ANSWER = 3'd3;
    localparam logic [2:0] ST_JUDGE  = 3'd4;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } bcd_pair_t;

    localparam bcd_t SCORE_MAX = 4'd9;

    function automatic bcd_pair_t to_bcd(input int secs);
        bcd_pair_t r;
        r.tens  = bcd_t'(secs / 10);
        r.units = bcd_t'(secs % 10);
        return r;
    endfunction

    // Stops at 00 rather than wrapping to 99.
    function automatic bcd_pair_t bcd_dec(input bcd_pair_t t);
        bcd_pair_t r;
        r = t;
        if (t.units != 4'd0) begin
            r.units = t.units - 4'd1;
        end else if (t.tens != 4'd0) begin
            r.tens  = t.tens - 4'd1;
            r.units = 4'd9;
        end
        return r;
    endfunction

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// Player/host inputs and display/buzzer outputs of the round controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface quiz_round_ctrl_if;
    logic [3:0]  Key_In;
    logic        Host_Start;
    logic        Host_Correct;
    logic        Host_Wrong;
    logic        Score_Clear;
    logic [3:0]  Player_Number;
    logic [3:0]  TimerH;
    logic [3:0]  TimerL;
    logic [3:0]  Lockout;
    logic [15:0] Score;
    logic        Buzzer_Answer;
    logic        Buzzer_TimeOver;
    logic [2:0]  State_Out;

    modport master (
        output Key_In, Host_Start, Host_Correct, Host_Wrong, Score_Clear,
        input  Player_Number, TimerH, TimerL, Lockout, Score,
               Buzzer_Answer, Buzzer_TimeOver, State_Out
    );

    modport slave (
        input  Key_In, Host_Start, Host_Correct, Host_Wrong, Score_Clear,
        output Player_Number, TimerH, TimerL, Lockout, Score,
               Buzzer_Answer, Buzzer_TimeOver, State_Out
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick: first unmasked requester at or after ptr.
// Latency: combinational.
// Backpressure: none; the caller owns and advances the pointer.
module rr_arbiter4
    import responder_pkg::*;
(
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic       valid
);
    logic [3:0] eff;
    logic [1:0] idx;

    always_comb begin
        eff   = req & mask;
        grant = 4'b0000;
        valid = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            idx = ptr + 2'(i);
            if (!valid && eff[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/quiz_round_ctrl.sv
// Round sequencer + buzz-in arbiter; option FALSE_START_LOCKOUT_EN locks early pressers.
// Latency: inputs edge-detected and acted on at the first clock they are seen high.
// Backpressure: none; buzzer outputs are single-cycle pulses.
module quiz_round_ctrl
    import responder_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int ARM_SECS  = 3,
    parameter int OPEN_SECS = 10,
    parameter int ANS_SECS  = 20
) (
    input logic              CLK,
    input logic              RSTn,
    quiz_round_ctrl_if.slave bus
);
    localparam int        PW       = $clog2(TICK_DIV);
    localparam bcd_pair_t ARM_BCD  = to_bcd(ARM_SECS);
    localparam bcd_pair_t OPEN_BCD = to_bcd(OPEN_SECS);
    localparam bcd_pair_t ANS_BCD  = to_bcd(ANS_SECS);

    logic [2:0]    state;
    bcd_pair_t     timer;
    logic [PW-1:0] presc;
    logic [1:0]    ptr, win, gnt_idx;
    logic          verdict_ok;
    logic [3:0]    lockout, player_num, grant, cur_score, next_score;
    logic [15:0]   score;
    logic          buz_ans, buz_to;
    logic [3:0]    key_q, key_edge;
    logic          start_q, corr_q, wrong_q;
    logic          start_edge, corr_edge, wrong_edge;
    logic          counting, tick, expire, arb_vld, all_locked;

    assign key_edge   = bus.Key_In & ~key_q;
    assign start_edge = bus.Host_Start & ~start_q;
    assign corr_edge  = bus.Host_Correct & ~corr_q;
    assign wrong_edge = bus.Host_Wrong & ~wrong_q;

    assign counting = (state == ST_ARMED) || (state == ST_OPEN) || (state == ST_ANSWER);
    assign tick     = counting && (presc == PW'(TICK_DIV - 1));
    // Firing on the 01 -> 00 tick means a phase lasts exactly SECS * TICK_DIV cycles.
    assign expire   = tick && (timer.tens == 4'd0) && (timer.units == 4'd1);

    rr_arbiter4 u_arb (
        .req   (key_edge),
        .mask  (~lockout),
        .ptr   (ptr),
        .grant (grant),
        .valid (arb_vld)
    );

    always_comb begin
        gnt_idx = 2'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (grant[i]) gnt_idx = 2'(i);
        end
    end

    assign cur_score  = score[{win, 2'b00} +: 4];
    assign next_score = (cur_score >= SCORE_MAX) ? SCORE_MAX : cur_score + 4'd1;
    assign all_locked = ((lockout | (4'b0001 << win)) == 4'b1111);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            timer      <= '0;
            presc      <= '0;
            ptr        <= 2'd0;
            win        <= 2'd0;
            verdict_ok <= 1'b0;
            lockout    <= 4'b0000;
            player_num <= 4'd0;
            score      <= 16'h0000;
            buz_ans    <= 1'b0;
            buz_to     <= 1'b0;
            key_q      <= 4'b0000;
            start_q    <= 1'b0;
            corr_q     <= 1'b0;
            wrong_q    <= 1'b0;
        end else begin
            key_q   <= bus.Key_In;
            start_q <= bus.Host_Start;
            corr_q  <= bus.Host_Correct;
            wrong_q <= bus.Host_Wrong;
            buz_ans <= 1'b0;
            buz_to  <= 1'b0;

            if (counting) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) timer <= bcd_dec(timer);
            end

            // Abort outranks any grant or timeout landing in the same cycle.
            if (start_edge && counting) begin
                state      <= ST_IDLE;
                timer      <= '0;
                presc      <= '0;
                lockout    <= 4'b0000;
                player_num <= 4'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.Score_Clear) score <= 16'h0000;
                        if (start_edge) begin
                            state      <= ST_ARMED;
                            timer      <= ARM_BCD;
                            presc      <= '0;
                            lockout    <= 4'b0000;
                            player_num <= 4'd0;
                        end
                    end
                    ST_ARMED: begin
`ifdef FALSE_START_LOCKOUT_EN
                        lockout <= lockout | key_edge;
                        if (expire) begin
                            presc <= '0;
                            if ((lockout | key_edge) == 4'b1111) begin
                                state  <= ST_IDLE;
                                timer  <= '0;
                                buz_to <= 1'b1;
                            end else begin
                                state <= ST_OPEN;
                                timer <= OPEN_BCD;
                            end
                        end
`else
                        if (expire) begin
                            state <= ST_OPEN;
                            timer <= OPEN_BCD;
                            presc <= '0;
                        end
`endif
                    end
                    ST_OPEN: begin
                        if (arb_vld) begin
                            state      <= ST_ANSWER;
                            timer      <= ANS_BCD;
                            presc      <= '0;
                            win        <= gnt_idx;
                            player_num <= {2'b00, gnt_idx} + 4'd1;
                            ptr        <= gnt_idx + 2'd1;
                            buz_ans    <= 1'b1;
                        end else if (expire) begin
                            state  <= ST_IDLE;
                            timer  <= '0;
                            presc  <= '0;
                            buz_to <= 1'b1;
                        end
                    end
                    ST_ANSWER: begin
                        if (corr_edge) begin
                            state      <= ST_JUDGE;
                            verdict_ok <= 1'b1;
                        end else if (wrong_edge || expire) begin
                            state      <= ST_JUDGE;
                            verdict_ok <= 1'b0;
                            buz_to     <= expire;
                        end
                    end
                    ST_JUDGE: begin
                        presc <= '0;
                        if (verdict_ok) begin
                            score[{win, 2'b00} +: 4] <= next_score;
                            state <= ST_IDLE;
                            timer <= '0;
                        end else begin
                            lockout[win] <= 1'b1;
                            player_num   <= 4'd0;
                            if (all_locked) begin
                                state <= ST_IDLE;
                                timer <= '0;
                            end else begin
                                state <= ST_OPEN;
                                timer <= OPEN_BCD;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.Player_Number   = player_num;
    assign bus.TimerH          = timer.tens;
    assign bus.TimerL          = timer.units;
    assign bus.Lockout         = lockout;
    assign bus.Score           = score;
    assign bus.Buzzer_Answer   = buz_ans;
    assign bus.Buzzer_TimeOver = buz_to;
    assign bus.State_Out       = state;
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: every state change is checked against a queue of
// hand-computed snapshots (outputs + cycles spent in the previous state).
module tb_quiz_round_ctrl;
    import responder_pkg::*;

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  pn;
        logic [7:0]  tmr;
        logic [3:0]  lk;
        logic [15:0] sc;
        logic        ba;
        logic        bt;
    } snap_t;

    typedef struct {
        snap_t s;
        int    dly;
    } exp_t;

    logic CLK;
    logic RSTn;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    quiz_round_ctrl_if bus ();

    quiz_round_ctrl #(
        .TICK_DIV  (4),
        .ARM_SECS  (2),
        .OPEN_SECS (3),
        .ANS_SECS  (2)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic snap_t sample();
        snap_t s;
        s.st  = bus.State_Out;
        s.pn  = bus.Player_Number;
        s.tmr = {bus.TimerH, bus.TimerL};
        s.lk  = bus.Lockout;
        s.sc  = bus.Score;
        s.ba  = bus.Buzzer_Answer;
        s.bt  = bus.Buzzer_TimeOver;
        return s;
    endfunction

    task automatic push(input logic [2:0] st, input logic [3:0] pn, input logic [7:0] tm,
                        input logic [3:0] lk, input logic [15:0] sc, input logic ba,
                        input logic bt, input int dly);
        exp_t e;
        e.s   = '{st: st, pn: pn, tmr: tm, lk: lk, sc: sc, ba: ba, bt: bt};
        e.dly = dly;
        exp_q.push_back(e);
    endtask

    // Monitor: compares on every State_Out change, then checks pulses dropped next cycle.
    initial begin : monitor
        logic [2:0] prev_st;
        int         cnt;
        bit         chk_pulse;
        exp_t       e;
        snap_t      act;
        prev_st   = 3'd0;
        cnt       = 0;
        chk_pulse = 1'b0;
        forever begin
            @(negedge CLK);
            cnt++;
            act = sample();
            if (act.st !== prev_st) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_transition got=%h", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e.s) begin
                        bad++;
                        $display("FAIL transition_to_%0d got=%h want=%h", e.s.st, act, e.s);
                    end
                    if (e.dly != 0) begin
                        total++;
                        if (cnt != e.dly) begin
                            bad++;
                            $display("FAIL duration_before_%0d got=%0d want=%0d", e.s.st, cnt, e.dly);
                        end
                    end
                end
                prev_st   = act.st;
                cnt       = 0;
                chk_pulse = 1'b1;
            end else if (chk_pulse) begin
                total++;
                if ({act.ba, act.bt} !== 2'b00) begin
                    bad++;
                    $display("FAIL pulse_width got=%b want=00", {act.ba, act.bt});
                end
                chk_pulse = 1'b0;
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_zero(input string name);
        snap_t s;
        s = sample();
        total++;
        if (s !== '0) begin
            bad++;
            $display("FAIL %s got=%h want=0", name, s);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (bus.State_Out !== st && n < budget) begin
            tick_n(1);
            n++;
        end
        if (bus.State_Out !== st) begin
            total++;
            bad++;
            $display("FAIL wait_state got=%0d want=%0d", bus.State_Out, st);
        end
    endtask

    task automatic press(input logic [3:0] keys);
        bus.Key_In = keys;
        tick_n(1);
        bus.Key_In = 4'b0000;
        tick_n(1);
    endtask

    task automatic pulse_start();
        bus.Host_Start = 1'b1;
        tick_n(1);
        bus.Host_Start = 1'b0;
        tick_n(1);
    endtask

    task automatic pulse_correct();
        bus.Host_Correct = 1'b1;
        tick_n(1);
        bus.Host_Correct = 1'b0;
        tick_n(1);
    endtask

    task automatic pulse_wrong();
        bus.Host_Wrong = 1'b1;
        tick_n(1);
        bus.Host_Wrong = 1'b0;
        tick_n(1);
    endtask

    task automatic pulse_clear();
        bus.Score_Clear = 1'b1;
        tick_n(1);
        bus.Score_Clear = 1'b0;
        tick_n(1);
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge arrives.
    task automatic apply_reset(input string name);
        @(posedge CLK);
        #2 RSTn = 1'b0;
        #1 check_zero(name);
        #1 RSTn = 1'b1;
        tick_n(1);
    endtask

    // Starts a round and waits for OPEN; ARMED must last 2 s * 4 cycles.
    task automatic start_round(input logic [15:0] sc, input logic [3:0] open_lk);
        push(ST_ARMED, 4'd0, 8'h02, 4'b0000, sc, 1'b0, 1'b0, 0);
        push(ST_OPEN, 4'd0, 8'h03, open_lk, sc, 1'b0, 1'b0, 8);
        pulse_start();
        wait_state(ST_OPEN, 40);
    endtask

    task automatic win_correct(input logic [3:0] keys, input logic [3:0] pn,
                               input logic [15:0] sc, input logic [15:0] sc_new);
        push(ST_ANSWER, pn, 8'h02, 4'b0000, sc, 1'b1, 1'b0, 0);
        press(keys);
        push(ST_JUDGE, pn, 8'h02, 4'b0000, sc, 1'b0, 1'b0, 0);
        push(ST_IDLE, pn, 8'h00, 4'b0000, sc_new, 1'b0, 1'b0, 1);
        pulse_correct();
        wait_state(ST_IDLE, 20);
    endtask

    logic [3:0] win_tab[4];
    logic [3:0] lk_tab[5];
    logic [3:0] s4;
    logic [15:0] sc_cur;

    initial begin
        RSTn             = 1'b0;
        bus.Key_In       = 4'b0000;
        bus.Host_Start   = 1'b0;
        bus.Host_Correct = 1'b0;
        bus.Host_Wrong   = 1'b0;
        bus.Score_Clear  = 1'b0;
        tick_n(3);
        check_zero("reset_outputs");
        RSTn = 1'b1;
        tick_n(2);

        // 1: player 3 alone wins the first round, then correct.
        start_round(16'h0000, 4'b0000);
        win_correct(4'b0100, 4'd3, 16'h0000, 16'h0100);

        // 2: from reset, players 2+4 together twice; pointer rotates 2 then 4.
        apply_reset("reset_idle");
        start_round(16'h0000, 4'b0000);
        win_correct(4'b1010, 4'd2, 16'h0000, 16'h0010);
        start_round(16'h0010, 4'b0000);
        win_correct(4'b1010, 4'd4, 16'h0010, 16'h1010);

        // 3: player 1 wrong -> locked out, re-press ignored, player 2 wins; then abort.
        start_round(16'h1010, 4'b0000);
        push(ST_ANSWER, 4'd1, 8'h02, 4'b0000, 16'h1010, 1'b1, 1'b0, 0);
        press(4'b0001);
        push(ST_JUDGE, 4'd1, 8'h02, 4'b0000, 16'h1010, 1'b0, 1'b0, 0);
        push(ST_OPEN, 4'd0, 8'h03, 4'b0001, 16'h1010, 1'b0, 1'b0, 1);
        pulse_wrong();
        wait_state(ST_OPEN, 10);
        press(4'b0001);
        push(ST_ANSWER, 4'd2, 8'h02, 4'b0001, 16'h1010, 1'b1, 1'b0, 0);
        press(4'b0010);
        push(ST_IDLE, 4'd0, 8'h00, 4'b0000, 16'h1010, 1'b0, 1'b0, 0);
        pulse_start();
        wait_state(ST_IDLE, 10);

        // 3b: everyone presses, each winner judged wrong until all four are locked.
        win_tab = '{4'd3, 4'd4, 4'd1, 4'd2};
        lk_tab  = '{4'b0000, 4'b0100, 4'b1100, 4'b1101, 4'b1111};
        start_round(16'h1010, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            push(ST_ANSWER, win_tab[i], 8'h02, lk_tab[i], 16'h1010, 1'b1, 1'b0, 0);
            press(4'b1111);
            push(ST_JUDGE, win_tab[i], 8'h02, lk_tab[i], 16'h1010, 1'b0, 1'b0, 0);
            if (i < 3)
                push(ST_OPEN, 4'd0, 8'h03, lk_tab[i+1], 16'h1010, 1'b0, 1'b0, 1);
            else
                push(ST_IDLE, 4'd0, 8'h00, lk_tab[4], 16'h1010, 1'b0, 1'b0, 1);
            pulse_wrong();
        end
        wait_state(ST_IDLE, 10);

        // 4: player 4 correct ten times; score climbs from 1 and sticks at 9.
        s4 = 4'd1;
        for (int r = 0; r < 10; r++) begin
            sc_cur = {s4, 12'h010};
            s4     = (s4 < 4'd9) ? s4 + 4'd1 : 4'd9;
            start_round(sc_cur, 4'b0000);
            win_correct(4'b1000, 4'd4, sc_cur, {s4, 12'h010});
        end

        // 5: silent OPEN times out after 12 cycles; Score_Clear ignored there, honoured in IDLE.
        push(ST_ARMED, 4'd0, 8'h02, 4'b0000, 16'h9010, 1'b0, 1'b0, 0);
        push(ST_OPEN, 4'd0, 8'h03, 4'b0000, 16'h9010, 1'b0, 1'b0, 8);
        push(ST_IDLE, 4'd0, 8'h00, 4'b0000, 16'h9010, 1'b0, 1'b1, 12);
        pulse_start();
        wait_state(ST_OPEN, 40);
        pulse_clear();
        wait_state(ST_IDLE, 40);
        pulse_clear();

        // 5b: answer timeout -> JUDGE with TimeOver, player locked, then abort from OPEN.
        start_round(16'h0000, 4'b0000);
        push(ST_ANSWER, 4'd1, 8'h02, 4'b0000, 16'h0000, 1'b1, 1'b0, 0);
        press(4'b0001);
        push(ST_JUDGE, 4'd1, 8'h00, 4'b0000, 16'h0000, 1'b0, 1'b1, 8);
        push(ST_OPEN, 4'd0, 8'h03, 4'b0001, 16'h0000, 1'b0, 1'b0, 1);
        wait_state(ST_OPEN, 40);
        push(ST_IDLE, 4'd0, 8'h00, 4'b0000, 16'h0000, 1'b0, 1'b0, 0);
        pulse_start();
        wait_state(ST_IDLE, 10);

        // 6: player 2 presses during ARMED, then reset lands mid-ANSWER.
        push(ST_ARMED, 4'd0, 8'h02, 4'b0000, 16'h0000, 1'b0, 1'b0, 0);
        pulse_start();
        wait_state(ST_ARMED, 10);
`ifdef FALSE_START_LOCKOUT_EN
        push(ST_OPEN, 4'd0, 8'h03, 4'b0010, 16'h0000, 1'b0, 1'b0, 8);
        press(4'b0010);
        wait_state(ST_OPEN, 40);
        press(4'b0010);
        push(ST_ANSWER, 4'd3, 8'h02, 4'b0010, 16'h0000, 1'b1, 1'b0, 0);
        press(4'b0100);
`else
        push(ST_OPEN, 4'd0, 8'h03, 4'b0000, 16'h0000, 1'b0, 1'b0, 8);
        press(4'b0010);
        wait_state(ST_OPEN, 40);
        push(ST_ANSWER, 4'd2, 8'h02, 4'b0000, 16'h0000, 1'b1, 1'b0, 0);
        press(4'b0010);
`endif
        push(ST_IDLE, 4'd0, 8'h00, 4'b0000, 16'h0000, 1'b0, 1'b0, 0);
        apply_reset("reset_mid_answer");

        tick_n(5);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_transitions got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
